comparador_8b: RTL and testbench

- Magnitude comparator for two unsigned operands `a` and `b`.
- Provides a zero-latency combinational result `c` (1 when a > b), which is checked against a software reference model.
- Also provides a registered copy of the full relation (gt/eq/lt) for synchronous consumers downstream.
- Sits as a leaf datapath block; no handshake with neighbours.

---
 rtl/comparador_8b.sv | 93 +++++++++
 tb/tb_comparador_8b.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/comparador_8b.sv
// comparador_8b
// -------------
// Magnitude comparator for two WIDTH-bit operands. It provides a
// zero-latency combinational "a greater than b" result and a registered
// copy of the full relation for synchronous consumers downstream.
//
// Parameters:
//   WIDTH   operand width in bits (>= 1)
//   SIGNED  0 = unsigned compare, 1 = two's-complement compare
//
// Ports:
//   clk      input   rising-edge clock for all registers
//   rst_n    input   asynchronous active-low reset
//   a        input   operand A, WIDTH bits
//   b        input   operand B, WIDTH bits
//   c        output  combinational: 1 when a > b
//   gt_q     output  registered: a > b at the last capturing edge
//   eq_q     output  registered: a == b at the last capturing edge
//   lt_q     output  registered: a < b at the last capturing edge
//   valid_q  output  registered: 1 once an edge has occurred after reset
module comparador_8b #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             c,
    output logic             gt_q,
    output logic             eq_q,
    output logic             lt_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] aKey;
    logic [WIDTH-1:0] bKey;
    logic [WIDTH:0]   diff;
    logic             ltNow;
    logic             eqNow;
    logic             gtNow;
    logic             gt_d;
    logic             eq_d;
    logic             lt_d;
    logic             valid_d;

    // Inverting the sign bit maps two's-complement values onto an
    // order-preserving unsigned range, so one unsigned comparator
    // serves both modes.
    always_comb begin
        aKey = a;
        bKey = b;
        if (SIGNED != 0) begin
            aKey[WIDTH-1] = ~a[WIDTH-1];
            bKey[WIDTH-1] = ~b[WIDTH-1];
        end
    end

    // The extra top bit of the subtraction is the borrow, which is set
    // exactly when aKey < bKey and can never overflow.
    always_comb begin
        diff  = {1'b0, aKey} - {1'b0, bKey};
        ltNow = diff[WIDTH];
        eqNow = (aKey == bKey);
        gtNow = ~ltNow & ~eqNow;
    end

    assign c = gtNow;

    // Next-state for the registered relation; valid only ever rises
    // after reset and holds until the next reset.
    always_comb begin
        gt_d    = gtNow;
        eq_d    = eqNow;
        lt_d    = ltNow;
        valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_comparador_8b.sv
// tb_comparador_8b
// ----------------
// Self-checking bench for comparador_8b. One unsigned and one signed
// instance share the same operands; expectations come from a vector table
// and from an integer-valued reference model of the comparison.
module tb_comparador_8b;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cU, gtU, eqU, ltU, validU;
    logic       cS, gtS, eqS, ltS, validS;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] av;
        logic [7:0] bv;
        bit         sgn;
        bit         expC;
        bit         expGt;
        bit         expEq;
        bit         expLt;
    } vector_t;

    vector_t vecs [10];

    comparador_8b #(.WIDTH(8), .SIGNED(0)) dutU (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(cU),
        .gt_q(gtU), .eq_q(eqU), .lt_q(ltU), .valid_q(validU)
    );

    comparador_8b #(.WIDTH(8), .SIGNED(1)) dutS (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(cS),
        .gt_q(gtS), .eq_q(eqS), .lt_q(ltS), .valid_q(validS)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: interpret the bit pattern as an integer value.
    function automatic int toValue(input logic [7:0] v, input bit sgn);
        if (sgn && v[7]) return int'(v) - 256;
        return int'(v);
    endfunction

    function automatic bit refGt(input logic [7:0] x, input logic [7:0] y, input bit sgn);
        return toValue(x, sgn) > toValue(y, sgn);
    endfunction

    function automatic bit refLt(input logic [7:0] x, input logic [7:0] y, input bit sgn);
        return toValue(x, sgn) < toValue(y, sgn);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (a=%0d b=%0d t=%0t)", name, actual, expected, a, b, $time);
        end
    endtask

    // Change operands away from the clock edge and let combinational logic settle.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        #1;
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    // Compare registered flags of both instances against the model for the
    // operands that were present at the last edge.
    task automatic checkFlags(input string name, input logic [7:0] av, input logic [7:0] bv);
        bit g, l;
        g = refGt(av, bv, 1'b0);
        l = refLt(av, bv, 1'b0);
        checkOutput({name, " gtU"}, gtU, g);
        checkOutput({name, " eqU"}, eqU, !g && !l);
        checkOutput({name, " ltU"}, ltU, l);
        checkOutput({name, " validU"}, validU, 1);
        checkOutput({name, " onehotU"}, gtU + eqU + ltU, 1);
        g = refGt(av, bv, 1'b1);
        l = refLt(av, bv, 1'b1);
        checkOutput({name, " gtS"}, gtS, g);
        checkOutput({name, " eqS"}, eqS, !g && !l);
        checkOutput({name, " ltS"}, ltS, l);
        checkOutput({name, " validS"}, validS, 1);
        checkOutput({name, " onehotS"}, gtS + eqS + ltS, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = 8'd0;
        b      = 8'd0;

        vecs[0] = '{8'd200,  8'd17,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'd0,    8'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'd255,  8'd255,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'd255,  8'd0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'd3,    8'd250,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h80,   8'h7F,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h7F,   8'hFF,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hFF,   8'hFF,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'h80,   8'h7F,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{8'hFF,   8'h00,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state: flags cleared, c already live.
        #1;
        checkOutput("reset gtU", gtU, 0);
        checkOutput("reset eqU", eqU, 0);
        checkOutput("reset ltU", ltU, 0);
        checkOutput("reset validU", validU, 0);
        checkOutput("reset validS", validS, 0);
        a = 8'd9;
        b = 8'd4;
        #1;
        checkOutput("reset c tracks", cU, 1);

        // Release reset away from an edge; nothing captured until the edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("pre-edge validU", validU, 0);
        waitEdge();
        checkFlags("first capture", 8'd9, 8'd4);

        // Random combinational sweep, no clock edge needed.
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            #1;
            checkOutput("rand cU", cU, refGt(a, b, 1'b0));
            checkOutput("rand cS", cS, refGt(a, b, 1'b1));
        end

        // Table-driven vectors: combinational result, then registered flags.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].av, vecs[i].bv);
            checkOutput($sformatf("vec%0d c", i), vecs[i].sgn ? cS : cU, vecs[i].expC);
            waitEdge();
            checkOutput($sformatf("vec%0d gt", i), vecs[i].sgn ? gtS : gtU, vecs[i].expGt);
            checkOutput($sformatf("vec%0d eq", i), vecs[i].sgn ? eqS : eqU, vecs[i].expEq);
            checkOutput($sformatf("vec%0d lt", i), vecs[i].sgn ? ltS : ltU, vecs[i].expLt);
            checkOutput($sformatf("vec%0d valid", i), vecs[i].sgn ? validS : validU, 1);
        end

        // Mid-cycle reset: flags drop at once, c keeps tracking.
        applyStimulus(8'd3, 8'd250);
        waitEdge();
        checkOutput("pre-reset ltU", ltU, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async gtU", gtU, 0);
        checkOutput("async eqU", eqU, 0);
        checkOutput("async ltU", ltU, 0);
        checkOutput("async validU", validU, 0);
        checkOutput("async ltS", ltS, 0);
        checkOutput("async cU", cU, 0);
        a = 8'd251;
        #1;
        checkOutput("reset cU tracks", cU, 1);
        waitEdge();
        checkOutput("held ltU", ltU, 0);
        checkOutput("held validU", validU, 0);
        @(negedge clk);
        rst_n = 1'b1;
        waitEdge();
        checkFlags("after re-release", 8'd251, 8'd250);

        // Random clocked run: registered relation and one-hot flags.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = (i % 7 == 0) ? ra : 8'($urandom);
            applyStimulus(ra, rb);
            checkOutput("rand clk cU", cU, refGt(ra, rb, 1'b0));
            waitEdge();
            checkFlags("rand clk", ra, rb);
            checkOutput("gt equals c", gtU, cU);
        end

        // Exhaustive combinational sweep for both modes.
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                a = 8'(ia);
                b = 8'(ib);
                #1;
                checkOutput("exh cU", cU, refGt(a, b, 1'b0));
                checkOutput("exh cS", cS, refGt(a, b, 1'b1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
